// File: rtl/rib_xbar_pkg.sv
// rib_xbar_pkg: shared constants and types for the RIB crossbar.
// Request encodings, arbiter FSM states and default bus widths.
package rib_xbar_pkg;

   localparam logic RIB_REQ  = 1'b1;
   localparam logic RIB_NREQ = 1'b0;

   localparam int RIB_DEF_MASTERS = 4;
   localparam int RIB_DEF_SLAVES  = 4;
   localparam int RIB_DEF_ADDR_W  = 32;
   localparam int RIB_DEF_DATA_W  = 32;
   localparam int RIB_DEF_SEL     = 4;
   localparam int RIB_DEF_BURST   = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } rib_state_e;

endpackage

// File: rtl/rib_xbar_rr_arb.sv
// rib_xbar_rr_arb: combinational round-robin search over a request vector.
// Ports: req_i/excl_i (N), start_i (W) in; found_o, idx_o (W) out.
module rib_xbar_rr_arb
   import rib_xbar_pkg::*;
#(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] start_i,
   input  logic [N-1:0] excl_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);

   logic [N-1:0] avail;

   assign avail = req_i & ~excl_i;

   // Offset i from start lands on j when start == (j - i) mod N.
   // Scanning offsets downward leaves the nearest hit as the result.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         for (int j = 0; j < N; j++) begin
            if (avail[j] == RIB_REQ &&
                start_i == W'((j - i + N) % N)) begin
               found_o = 1'b1;
               idx_o   = W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/rib_xbar.sv
// rib_xbar: NUM_MASTERS x NUM_SLAVES RIB crossbar, round-robin + burst limit.
// In : clk, rst, m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i.
// Out: m_data_o, m_hold_o, s_addr_o, s_data_o, s_we_o, grant_o, busy_o.
// Define RIB_DECODE_ERR_EN to add err_o and release on unmapped access.
module rib_xbar
   import rib_xbar_pkg::*;
#(
   parameter int NUM_MASTERS = RIB_DEF_MASTERS,
   parameter int NUM_SLAVES  = RIB_DEF_SLAVES,
   parameter int ADDR_W      = RIB_DEF_ADDR_W,
   parameter int DATA_W      = RIB_DEF_DATA_W,
   parameter int SEL_BITS    = RIB_DEF_SEL,
   parameter int BURST_MAX   = RIB_DEF_BURST
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_MASTERS-1:0]        m_req_i,
   input  logic [NUM_MASTERS-1:0]        m_we_i,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_data_i,
   output logic [NUM_MASTERS*DATA_W-1:0] m_data_o,
   output logic [NUM_MASTERS-1:0]        m_hold_o,
   output logic [NUM_SLAVES*ADDR_W-1:0]  s_addr_o,
   output logic [NUM_SLAVES*DATA_W-1:0]  s_data_o,
   output logic [NUM_SLAVES-1:0]         s_we_o,
   input  logic [NUM_SLAVES*DATA_W-1:0]  s_data_i,
   output logic [NUM_MASTERS-1:0]        grant_o,
   output logic                          busy_o
`ifdef RIB_DECODE_ERR_EN
   ,
   output logic [NUM_MASTERS-1:0]        err_o
`endif
);

   localparam int OW = $clog2(NUM_MASTERS);
   localparam int CW = $clog2(BURST_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [SEL_BITS:0] NS_L = (SEL_BITS + 1)'(NUM_SLAVES);

   function automatic logic [NUM_MASTERS-1:0] onehot(
      input logic [OW-1:0] i
   );
      logic [NUM_MASTERS-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_MASTERS; k++)
         r[k] = (i == OW'(k));
      return r;
   endfunction

   rib_state_e             state_q, state_d;
   logic [OW-1:0]          own_q, own_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [OW-1:0]          rr_q, rr_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;

   logic                   busy;
   logic [NUM_MASTERS-1:0] own_oh;
   logic [OW-1:0]          own_inc;
   logic [ADDR_W-1:0]      own_addr;
   logic [DATA_W-1:0]      own_wdata;
   logic                   own_req;
   logic                   own_we;
   logic [SEL_BITS-1:0]    idx;
   logic                   mapped;
   logic [DATA_W-1:0]      rdata;
   logic [ADDR_W-1:0]      bc_addr;
   logic [DATA_W-1:0]      bc_data;
   logic                   others;
   logic                   burst_hit;
   logic                   rel;

   logic [OW-1:0]          arb_start;
   logic [NUM_MASTERS-1:0] arb_excl;
   logic                   arb_found;
   logic [OW-1:0]          arb_idx;

   assign busy    = (state_q == BUSY);
   assign own_oh  = onehot(own_q);
   assign own_inc = (own_q == OW'(NUM_MASTERS - 1)) ?
                    '0 : own_q + OW'(1);

   // Owner-side request mux.
   always_comb begin
      own_addr  = '0;
      own_wdata = '0;
      own_req   = RIB_NREQ;
      own_we    = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (own_q == OW'(k)) begin
            own_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
            own_wdata = m_data_i[k*DATA_W +: DATA_W];
            own_req   = m_req_i[k];
            own_we    = m_we_i[k];
         end
      end
   end

   assign idx    = own_addr[ADDR_W-1 -: SEL_BITS];
   assign mapped = ({1'b0, idx} < NS_L);

   // Slave-side datapath; idle bus drives zeros.
   assign bc_addr  = busy ? own_addr : '0;
   assign bc_data  = busy ? own_wdata : '0;
   assign s_addr_o = {NUM_SLAVES{bc_addr}};
   assign s_data_o = {NUM_SLAVES{bc_data}};

   always_comb begin
      s_we_o = '0;
      rdata  = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         if (idx == SEL_BITS'(s)) begin
            s_we_o[s] = busy && mapped && own_we &&
                        (own_req == RIB_REQ);
            rdata     = s_data_i[s*DATA_W +: DATA_W];
         end
      end
   end

   // Read data only reaches the owner's lane; unmapped reads give 0.
   always_comb begin
      m_data_o = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (busy && mapped && own_q == OW'(k))
            m_data_o[k*DATA_W +: DATA_W] = rdata;
      end
   end

   assign m_hold_o = m_req_i & ~grant_q;
   assign grant_o  = grant_q;
   assign busy_o   = busy;

   // One search serves both cases: from rr_q when idle,
   // from the slot after the owner (owner excluded) when busy.
   assign arb_start = busy ? own_inc : rr_q;
   assign arb_excl  = busy ? own_oh : '0;

   rib_xbar_rr_arb #(
      .N (NUM_MASTERS),
      .W (OW)
   ) u_arb (
      .req_i   (m_req_i),
      .start_i (arb_start),
      .excl_i  (arb_excl),
      .found_o (arb_found),
      .idx_o   (arb_idx)
   );

   assign others    = |(m_req_i & ~own_oh);
   assign burst_hit = (own_req == RIB_REQ) && others &&
                      (cnt_q == CNT_MAX);

`ifdef RIB_DECODE_ERR_EN
   assign rel = (own_req == RIB_NREQ) || burst_hit || !mapped;
`else
   assign rel = (own_req == RIB_NREQ) || burst_hit;
`endif

   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      unique case (state_q)
         IDLE: begin
            if (arb_found) begin
               state_d = BUSY;
               own_d   = arb_idx;
               cnt_d   = CNT_ONE;
               grant_d = onehot(arb_idx);
            end
         end
         BUSY: begin
            if (rel) begin
               rr_d = own_inc;
               if (arb_found) begin
                  own_d   = arb_idx;
                  cnt_d   = CNT_ONE;
                  grant_d = onehot(arb_idx);
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         own_q   <= '0;
         cnt_q   <= '0;
         rr_q    <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
      end
   end

`ifdef RIB_DECODE_ERR_EN
   logic [NUM_MASTERS-1:0] err_q, err_d;

   assign err_d = (busy && !mapped) ? own_oh : '0;
   assign err_o = err_q;

   always_ff @(posedge clk) begin
      if (rst)
         err_q <= '0;
      else
         err_q <= err_d;
   end
`endif

endmodule

// File: doc/rib_xbar.md
Name: rib_xbar

Overview:
- Parametrised successor to the fixed 4-master/2-slave RIB interconnect.
- Connects NUM_MASTERS bus masters (core data port, PC fetch, debug/UART loader, DMA) to NUM_SLAVES memory-mapped slaves (rom, ram, timer, uart, gpio).
- Arbitration is round-robin with owner lock and a burst limit, replacing fixed priority, so no master starves.
- Drives per-master hold flags that the core uses to stall its pipeline.

Parameters:
- NUM_MASTERS, 4, number of masters (2..8).
- NUM_SLAVES, 4, number of slaves (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SEL_BITS, 4, slave index width; index = addr[ADDR_W-1 -: SEL_BITS].
- BURST_MAX, 16, max consecutive owned cycles while another master waits (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_req_i  in  NUM_MASTERS  per-master request
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_addr_i  in  NUM_MASTERS*ADDR_W  packed, master k at [k*ADDR_W +: ADDR_W]
- m_data_i  in  NUM_MASTERS*DATA_W  write data, packed likewise
- m_data_o  out  NUM_MASTERS*DATA_W  read data; valid only for the owner, 0 otherwise
- m_hold_o  out  NUM_MASTERS  stall: m_req_i[k] & ~granted[k]
- s_addr_o  out  NUM_SLAVES*ADDR_W  owner address, broadcast to every slave
- s_data_o  out  NUM_SLAVES*DATA_W  owner write data, broadcast
- s_we_o  out  NUM_SLAVES  write strobe, only to the decoded slave
- s_data_i  in  NUM_SLAVES*DATA_W  slave read data
- grant_o  out  NUM_MASTERS  one-hot registered owner, 0 when idle
- busy_o  out  1  state == BUSY

Behaviour:
- FSM states:
  - IDLE: no owner.
  - BUSY: owner index own_q, burst counter cnt_q.
- Reset (synchronous, takes effect mid-transaction too):
  - state=IDLE, grant_o=0, own_q=0, cnt_q=0, rr_ptr_q=0.
  - All s_we_o=0, all m_data_o=0, m_hold_o equals m_req_i.
- IDLE:
  - If any m_req_i is high, pick the first requester searching upward from rr_ptr_q, wrapping modulo NUM_MASTERS.
  - Next cycle: state=BUSY, grant_o=onehot(pick), cnt_q=1.
  - Arbitration latency is 1 cycle; the requester sees hold=1 for exactly 1 cycle.
- BUSY, datapath (combinational from own_q):
  - s_addr_o and s_data_o carry the owner's address and data.
  - Decode idx = owner addr[ADDR_W-1 -: SEL_BITS].
  - s_we_o[idx] = m_we_i[own] & m_req_i[own].
  - m_data_o[own] = s_data_i[idx].
  - If idx >= NUM_SLAVES: no strobe, read data 0.
- BUSY, owner drops its request:
  - Re-arbitrate among other requesters from own_q+1.
  - Hit: switch owner next cycle, cnt_q=1.
  - Miss: go to IDLE.
  - rr_ptr_q = own_q+1 mod NUM_MASTERS.
- BUSY, burst limit:
  - Condition: owner still requesting, another master requesting, and cnt_q == BURST_MAX.
  - Forced handover to the next requester after own_q, same timing as a voluntary release.
  - The preempted master holds until it is granted again.
- BUSY, no contention:
  - cnt_q saturates at BURST_MAX; ownership continues indefinitely.
- Grant and release on the same edge: the new owner takes effect next cycle. No cycle exists with two grants.
- Write and read occur in the same cycle under a grant. The slave is responsible for its own read latency, as with the existing rom/ram.

Optional Feature:
- Macro: RIB_DECODE_ERR_EN.
- Defined:
  - Adds output port err_o (NUM_MASTERS).
  - err_o[own] pulses 1 cycle, registered, for every granted cycle whose idx >= NUM_SLAVES.
  - An error also forces ownership release that cycle, as for a BURST_MAX handover.
- Undefined:
  - No port; unmapped accesses are silently dropped and read 0.

Decomposition:
- Shared package/defines (rib_defines.v): RIB_REQ/RIB_NREQ, state encodings IDLE/BUSY, default widths.
- One sub-module rib_rr_arb:
  - Inputs req vector, start pointer, exclude mask.
  - Outputs found flag and index.
  - Purely combinational; instantiated once.

Test Plan:
- Reset: assert rst mid-BUSY with m_req_i=4'b1111 -> next cycle grant_o=0, busy_o=0, m_hold_o=4'b1111, s_we_o=0.
- Single write: m0 req, we=1, addr 0x1000_0004, data 0xDEADBEEF -> 1 hold cycle, then s_we_o[1]=1 and s_data_o=0xDEADBEEF; readback returns 0xDEADBEEF on m_data_o[0].
- Round-robin: all 4 masters hold requests, BURST_MAX=4 -> grants rotate 0,1,2,3,0 every 4 cycles; each hold is low exactly while that master owns the bus.
- Voluntary release: m1 owns the bus and drops req at cycle 2 with m3 waiting -> grant_o=4'b1000 the next cycle, m3 hold clears.
- No contention: m1 alone requesting for 100 cycles -> grant stays 4'b0010, cnt_q saturates, no handover.
- Unmapped address: NUM_SLAVES=2, addr 0x3000_0000, write -> no s_we_o, read data 0; with RIB_DECODE_ERR_EN, err_o[own]=1 for 1 cycle followed by release.
